// File: rtl/seven_seg_scan_driver.sv
// Multiplexed 8-digit seven-segment scan driver with frame-synchronous shadowing.
// Optional anti-ghost blanking at each slot start: define SEVEN_SEG_SCAN_DRIVER_BLANK_EN.
module seven_seg_scan_driver #(
    parameter int PRESCALE     = 1024,
    parameter int BLANK_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  disp_en,
    input  logic [31:0] disp,
    input  logic [7:0]  disp_dot,
    output logic [7:0]  anode,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_start
);

    localparam int CW = $clog2(PRESCALE);

    if (PRESCALE < 2 || PRESCALE > 65536) begin : g_bad_prescale
        $error("PRESCALE out of range 2..65536");
    end
    if (BLANK_CYCLES < 1 || BLANK_CYCLES >= PRESCALE) begin : g_bad_blank
        $error("BLANK_CYCLES out of range 1..PRESCALE-1");
    end

    logic [CW-1:0] cnt;
    logic [2:0]    dig;
    logic          first;
    logic [7:0]    sh_en, sh_dot;
    logic [31:0]   sh_disp;

    logic          tick, load, blank, show;
    logic [7:0]    en_eff, dot_eff;
    logic [31:0]   disp_eff;
    logic [3:0]    nib;
    logic [7:0]    anode_d;
    logic [6:0]    seg_d;
    logic          dp_d;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: hex7 = 7'h3F;  4'h1: hex7 = 7'h06;  4'h2: hex7 = 7'h5B;  4'h3: hex7 = 7'h4F;
            4'h4: hex7 = 7'h66;  4'h5: hex7 = 7'h6D;  4'h6: hex7 = 7'h7D;  4'h7: hex7 = 7'h07;
            4'h8: hex7 = 7'h7F;  4'h9: hex7 = 7'h6F;  4'hA: hex7 = 7'h77;  4'hB: hex7 = 7'h7C;
            4'hC: hex7 = 7'h39;  4'hD: hex7 = 7'h5E;  4'hE: hex7 = 7'h79;  default: hex7 = 7'h71;
        endcase
    endfunction

    assign tick = (cnt == CW'(PRESCALE - 1));
    assign load = first | (tick & (dig == 3'd7));

`ifdef SEVEN_SEG_SCAN_DRIVER_BLANK_EN
    assign blank = (cnt < CW'(BLANK_CYCLES));
`else
    assign blank = 1'b0;
`endif

    // On the first cycle out of reset the shadow is loading this very edge, so
    // display from the inputs directly; digit 0 then gets its full slot.
    assign en_eff   = first ? disp_en  : sh_en;
    assign dot_eff  = first ? disp_dot : sh_dot;
    assign disp_eff = first ? disp     : sh_disp;

    always_comb begin
        nib     = disp_eff[{dig, 2'b00} +: 4];
        show    = en_eff[dig] & ~blank;
        anode_d = '0;
        seg_d   = '0;
        dp_d    = 1'b0;
        if (show) begin
            anode_d = 8'b1 << dig;
            seg_d   = hex7(nib);
            dp_d    = dot_eff[dig];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt         <= '0;
            dig         <= '0;
            first       <= 1'b1;
            sh_en       <= '0;
            sh_dot      <= '0;
            sh_disp     <= '0;
            anode       <= '0;
            seg         <= '0;
            dp          <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            first       <= 1'b0;
            cnt         <= tick ? '0 : cnt + 1'b1;
            if (tick) dig <= dig + 3'd1;
            if (load) begin
                sh_en   <= disp_en;
                sh_dot  <= disp_dot;
                sh_disp <= disp;
            end
            frame_start <= load;
            anode       <= anode_d;
            seg         <= seg_d;
            dp          <= dp_d;
        end
    end

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Bench for seven_seg_scan_driver (PRESCALE=4, BLANK_CYCLES=1): vector table,
// corner sequences, and randomized inputs against a frame/slot arithmetic model.
module tb_seven_seg_scan_driver;

    localparam int P = 4;
`ifdef SEVEN_SEG_SCAN_DRIVER_BLANK_EN
    localparam bit BLANK = 1'b1;
`else
    localparam bit BLANK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  disp_en = '0;
    logic [31:0] disp = '0;
    logic [7:0]  disp_dot = '0;
    logic [7:0]  anode;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_start;

    seven_seg_scan_driver #(.PRESCALE(P), .BLANK_CYCLES(1)) dut (
        .clk(clk), .rst(rst), .disp_en(disp_en), .disp(disp), .disp_dot(disp_dot),
        .anode(anode), .seg(seg), .dp(dp), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    int nchk = 0;
    int nfail = 0;

    typedef struct packed {
        logic [7:0]  en;
        logic [31:0] d;
        logic [7:0]  dot;
    } snap_t;

    // mk = number of non-reset edges since the last reset edge (-1 before any).
    int    mk = -1;
    snap_t snaps [64];
    logic [6:0] hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    // A frame's contents are captured at the first edge out of reset and at every 32nd edge.
    always @(posedge clk) begin
        if (rst) mk <= 0;
        else begin
            mk <= mk + 1;
            if (mk + 1 == 1 || (mk + 1) % 32 == 0)
                snaps[((mk + 1) / 32) % 64] <= '{disp_en, disp, disp_dot};
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        int p, s, ph;
        snap_t sn;
        logic [7:0] ea;
        logic [6:0] es;
        logic ed, ef;
        ea = '0; es = '0; ed = 1'b0; ef = 1'b0;
        if (mk < 0) return;
        if (mk > 0) begin
            p  = mk - 1;
            sn = snaps[(p / 32) % 64];
            s  = (p / P) % 8;
            ph = p % P;
            ef = (mk == 1) || (mk % 32 == 0);
            if (sn.en[s] && !(BLANK && ph < 1)) begin
                ea = 8'(1 << s);
                es = hex_tab[(sn.d >> (4 * s)) & 32'hF];
                ed = sn.dot[s];
            end
        end
        chk("model_anode", 32'(anode), 32'(ea));
        chk("model_seg", 32'(seg), 32'(es));
        chk("model_dp", 32'(dp), 32'(ed));
        chk("model_frame_start", 32'(frame_start), 32'(ef));
        chk("onehot_anode", 32'($onehot0(anode)), 32'd1);
    endtask

    task automatic tick();
        @(negedge clk);
        check_model();
    endtask

    task automatic wait_k(input int k);
        int n = 0;
        while (mk != k && n < 2000) begin tick(); n++; end
        if (mk != k) chk("wait_timeout", 32'(mk), 32'(k));
    endtask

    task automatic do_reset(input logic [7:0] en, input logic [31:0] d, input logic [7:0] dot);
        rst = 1'b1; disp_en = en; disp = d; disp_dot = dot;
        repeat (3) tick();
        rst = 1'b0;
    endtask

    typedef struct {
        logic [7:0]  en;
        logic [31:0] d;
        logic [7:0]  dot;
        int          slot;
        logic [7:0]  ea;
        logic [6:0]  es;
        logic        ed;
    } vec_t;

    vec_t vecs [12];

    initial begin
        vecs[0]  = '{8'hFF, 32'h76543210, 8'h00, 0, 8'h01, 7'h3F, 1'b0};
        vecs[1]  = '{8'hFF, 32'h76543210, 8'h00, 3, 8'h08, 7'h4F, 1'b0};
        vecs[2]  = '{8'hFF, 32'h76543210, 8'h00, 7, 8'h80, 7'h07, 1'b0};
        vecs[3]  = '{8'hAA, 32'h76543210, 8'h00, 0, 8'h00, 7'h00, 1'b0};
        vecs[4]  = '{8'hAA, 32'h76543210, 8'h00, 1, 8'h02, 7'h06, 1'b0};
        vecs[5]  = '{8'hAA, 32'h76543210, 8'hFF, 4, 8'h00, 7'h00, 1'b0};
        vecs[6]  = '{8'hFF, 32'h76543210, 8'h81, 0, 8'h01, 7'h3F, 1'b1};
        vecs[7]  = '{8'hFF, 32'h76543210, 8'h81, 7, 8'h80, 7'h07, 1'b1};
        vecs[8]  = '{8'hFF, 32'h76543210, 8'h81, 3, 8'h08, 7'h4F, 1'b0};
        vecs[9]  = '{8'hFF, 32'hFEDCBA98, 8'h00, 2, 8'h04, 7'h77, 1'b0};
        vecs[10] = '{8'hFF, 32'hFEDCBA98, 8'h00, 5, 8'h20, 7'h5E, 1'b0};
        vecs[11] = '{8'hFF, 32'h00000000, 8'h00, 6, 8'h40, 7'h3F, 1'b0};

        // reset state
        do_reset(8'hFF, 32'h76543210, 8'h00);
        chk("rst_anode", 32'(anode), 32'h0);
        chk("rst_seg", 32'(seg), 32'h0);
        chk("rst_dp", 32'(dp), 32'h0);
        chk("rst_frame_start", 32'(frame_start), 32'h0);

        // first cycle out of reset: snapshot pulse, digit 0 (dark if blanking)
        wait_k(1);
        chk("start_frame_start", 32'(frame_start), 32'h1);
        chk("start_anode", 32'(anode), BLANK ? 32'h0 : 32'h01);
        wait_k(2);
        chk("start_fs_drop", 32'(frame_start), 32'h0);
        chk("start_anode2", 32'(anode), 32'h01);
        wait_k(5);
        chk("slot1_first_cycle", 32'(anode), BLANK ? 32'h0 : 32'h02);

        foreach (vecs[i]) begin
            do_reset(vecs[i].en, vecs[i].d, vecs[i].dot);
            wait_k(vecs[i].slot * P + 3);
            chk($sformatf("vec%0d_anode", i), 32'(anode), 32'(vecs[i].ea));
            chk($sformatf("vec%0d_seg", i), 32'(seg), 32'(vecs[i].es));
            chk($sformatf("vec%0d_dp", i), 32'(dp), 32'(vecs[i].ed));
        end

        // no tearing: change mid-frame, visible only from the next frame
        do_reset(8'hFF, 32'h0, 8'h00);
        wait_k(15);
        disp = 32'hFFFFFFFF;
        wait_k(23);
        chk("tear_seg_d5", 32'(seg), 32'h3F);
        wait_k(31);
        chk("tear_seg_d7", 32'(seg), 32'h3F);
        wait_k(32);
        chk("tear_frame_start", 32'(frame_start), 32'h1);
        wait_k(35);
        chk("tear_next_seg", 32'(seg), 32'h71);
        chk("tear_next_anode", 32'(anode), 32'h01);

        // reset mid-frame at digit 5
        do_reset(8'hFF, 32'h76543210, 8'h00);
        wait_k(23);
        rst = 1'b1;
        tick();
        chk("midrst_anode", 32'(anode), 32'h0);
        chk("midrst_seg", 32'(seg), 32'h0);
        chk("midrst_fs", 32'(frame_start), 32'h0);
        rst = 1'b0;
        wait_k(2);
        chk("midrst_restart_anode", 32'(anode), 32'h01);

        // randomized inputs, occasional reset, model checks every cycle
        for (int i = 0; i < 1500; i++) begin
            disp_en  = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
            disp     = $urandom;
            disp_dot = 8'($urandom);
            rst      = ($urandom_range(0, 199) == 0);
            tick();
        end
        rst = 1'b0;
        repeat (40) tick();

        $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
        $finish;
    end

endmodule

// File: doc/seven_seg_scan_driver.md
SEVEN_SEG_SCAN_DRIVER -- requirements
Module: seven_seg_scan_driver

Interface
REQ-001 Parameter PRESCALE, default 1024: clock cycles per digit slot; legal range 2..65536.
REQ-002 Parameter BLANK_CYCLES, default 16: blanking cycles at the start of each slot; legal range 1..PRESCALE-1.
REQ-003 Port clk  input  1: single clock; all logic on its rising edge.
REQ-004 Port rst  input  1: synchronous, active-high reset.
REQ-005 Port disp_en  input  8: per-digit enable; bit i enables digit i.
REQ-006 Port disp  input  32: eight 4-bit hex nibbles; digit i = disp[4i+3:4i].
REQ-007 Port disp_dot  input  8: per-digit decimal point; bit i belongs to digit i.
REQ-008 Port anode  output  8: one-hot digit select, active-high; all zero means dark.
REQ-009 Port seg  output  7: segments {g,f,e,d,c,b,a}, active-high.
REQ-010 Port dp  output  1: decimal point, active-high.
REQ-011 Port frame_start  output  1: one-cycle pulse when a new snapshot is loaded.

Function
REQ-012 Prescaler cnt SHALL count 0..PRESCALE-1 and wrap; tick SHALL be asserted when cnt == PRESCALE-1.
REQ-013 Digit index dig (3 bits) SHALL increment modulo 8 on each tick: 7 -> 0.
REQ-014 Shadow registers for disp, disp_en and disp_dot SHALL load on a tick with dig == 7, and on the first cycle after rst deasserts; inputs SHALL NOT affect outputs at any other time (no tearing within a frame).
REQ-015 frame_start SHALL be 1 in the cycle after each shadow load; otherwise 0.
REQ-016 anode, seg and dp SHALL be registered with 1-cycle latency from dig and cnt.
REQ-017 When the slot is active: anode = 1 << dig, seg = hex pattern of shadow nibble dig, dp = shadow disp_dot[dig].
REQ-018 If shadow disp_en[dig] == 0: anode, seg and dp SHALL all be 0 for the whole slot.
REQ-019 Hex patterns (gfedcba) SHALL be: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
REQ-020 During a blanked cycle (see REQ-024): anode, seg and dp SHALL be 0.
REQ-021 At most one anode bit SHALL be set in any cycle.

Reset
REQ-022 When rst = 1 in a cycle: cnt, dig, shadow registers, anode, seg, dp and frame_start SHALL be 0 after that edge.
REQ-023 Reset asserted mid-slot or mid-frame SHALL abort the scan; after reset the scan SHALL restart at digit 0, cnt 0, and the shadow SHALL reload per REQ-014.

Configuration
REQ-024 Macro SEVEN_SEG_SCAN_DRIVER_BLANK_EN defined: cycles with cnt < BLANK_CYCLES SHALL be blanked (anti-ghosting). Macro undefined: no blanking; BLANK_CYCLES SHALL be ignored and REQ-017/REQ-018 apply for all PRESCALE cycles of the slot.

Verification (PRESCALE=4, BLANK_CYCLES=1)
REQ-025 Hold rst for 3 cycles, then release with disp=32'h76543210, disp_en=8'hFF, disp_dot=0 -> frame_start pulses once; anode walks 01,02,04,...,80, 4 cycles each; seg values are 3F,06,5B,4F,66,6D,7D,07.
REQ-026 disp_en=8'b1010_1010 -> anode never equals 01, 04, 10 or 40; during those slots seg=0 and dp=0.
REQ-027 Change disp from 32'h0 to 32'hFFFFFFFF while dig=3 -> digits 3..7 still show 3F; the next frame shows 71 on all digits; frame_start pulses at the frame boundary.
REQ-028 disp_dot=8'h81 -> dp=1 only while anode=01 or anode=80.
REQ-029 Macro defined -> the first cycle of every slot has anode=0; macro undefined -> anode is non-zero in every cycle once the scan has started (disp_en=FF).
REQ-030 Assert rst while dig=5 -> outputs are 0 on the next cycle; after release the scan restarts at anode=01.
